// File: rtl/eth_rx_payload_buf_pkg.sv
// Shared Ethernet receive constants and FSM state encodings.
package eth_pkg;
    localparam int          ETH_HDR_LEN      = 14;
    localparam logic [47:0] ETH_BCAST        = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETH_TYPE_DEFAULT = 16'h88B5;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t WR_WAIT_SOF = 2'd0;
    localparam wr_state_t WR_HDR      = 2'd1;
    localparam wr_state_t WR_PAYLOAD  = 2'd2;
    localparam wr_state_t WR_DROP     = 2'd3;

    typedef logic [0:0] rd_state_t;
    localparam rd_state_t RD_RUN = 1'b0;
    localparam rd_state_t RD_GAP = 1'b1;
endpackage

// File: rtl/eth_rx_payload_buf_if.sv
// MAC receive stream in, committed payload pop interface and status out.
interface eth_rx_payload_buf_if;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        i_rx_sof;
    logic        i_rx_last;
    logic        i_rx_err;
    logic [7:0]  o_rdata;
    logic        o_rlast;
    logic        o_rready;
    logic        i_rreq;
    logic [47:0] o_src_mac;
    logic [15:0] o_drop_cnt;

    modport slave (
        input  i_rx_data, i_rx_valid, i_rx_sof, i_rx_last, i_rx_err, i_rreq,
        output o_rdata, o_rlast, o_rready, o_src_mac, o_drop_cnt
    );
    modport master (
        output i_rx_data, i_rx_valid, i_rx_sof, i_rx_last, i_rx_err, i_rreq,
        input  o_rdata, o_rlast, o_rready, o_src_mac, o_drop_cnt
    );
endinterface

// File: rtl/eth_rx_payload_buf_ram_sdp.sv
// Simple dual-port RAM, one write port, one synchronous read port.
module ram_sdp #(
    parameter int AW = 11,
    parameter int DW = 9
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output register resets so the read port shows zero while in reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) rdata <= '0;
        else       rdata <= mem[raddr];
    end
endmodule

// File: rtl/eth_rx_payload_buf.sv
// Ethernet receive header filter feeding a frame-committed payload FIFO with an idle gap between frames.
module eth_rx_payload_buf
    import eth_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 11,
    parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE  = ETH_TYPE_DEFAULT,
    parameter int          GAP_CYCLES = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    eth_rx_payload_buf_if.slave bus
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] d);
        logic [16:0] s;
        s = {1'b0, c} + {15'd0, d};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    wr_state_t   wr_state, wr_state_n, cur;
    logic [3:0]  hdr_idx, hdr_idx_n, idx;
    logic        uc_ok, bc_ok, uc_ok_n, bc_ok_n, uc_next, bc_next, hdr_bad;
    logic [7:0]  rx_byte, mac_byte;
    logic        sof, full, we, commit_evt, shift_src;
    logic [1:0]  drops;
    logic [47:0] src_shadow, src_mac;
    logic [15:0] drop_cnt;
    logic [PW-1:0] wr_ptr, wr_ptr_n, commit_ptr, commit_n, commit_vis, rd_ptr, rd_next;
    rd_state_t   rd_state;
    logic [GW-1:0] gap_cnt;
    logic        rready, pop;
    logic [8:0]  rd_word;

    always_comb begin
        rx_byte    = bus.i_rx_data;
        sof        = bus.i_rx_valid && bus.i_rx_sof;
        idx        = sof ? 4'd0 : hdr_idx;
        mac_byte   = 8'(MAC_ADDR >> {3'd5 - idx[2:0], 3'b000});
        uc_next    = ((idx == 4'd0) || uc_ok) && (rx_byte == mac_byte);
        bc_next    = ((idx == 4'd0) || bc_ok) && (rx_byte == ETH_BCAST[7:0]);
        full       = (wr_ptr - rd_ptr) == DEPTH;
        wr_state_n = wr_state;
        hdr_idx_n  = hdr_idx;
        uc_ok_n    = uc_ok;
        bc_ok_n    = bc_ok;
        wr_ptr_n   = wr_ptr;
        commit_n   = commit_ptr;
        we         = 1'b0;
        commit_evt = 1'b0;
        shift_src  = 1'b0;
        hdr_bad    = 1'b0;
        drops      = 2'd0;
        cur        = wr_state;
        if (bus.i_rx_valid) begin
            // A start-of-frame aborts whatever was in flight; the SOF byte is header byte 0.
            if (sof) begin
                if (wr_state != WR_WAIT_SOF) drops = 2'd1;
                wr_ptr_n = commit_ptr;
                cur      = WR_HDR;
            end
            case (cur)
                WR_HDR: begin
                    hdr_idx_n = idx + 4'd1;
                    if (idx < 4'd6) begin
                        uc_ok_n = uc_next;
                        bc_ok_n = bc_next;
                        hdr_bad = !uc_next && !bc_next;
                    end else if (idx < 4'd12) begin
                        shift_src = 1'b1;
                    end else if (idx == 4'd12) begin
                        hdr_bad = rx_byte != ETHERTYPE[15:8];
                    end else begin
                        hdr_bad = rx_byte != ETHERTYPE[7:0];
                    end
                    if (bus.i_rx_last) begin
                        drops      = drops + 2'd1;
                        wr_ptr_n   = commit_ptr;
                        wr_state_n = WR_WAIT_SOF;
                    end else if (hdr_bad) begin
                        wr_state_n = WR_DROP;
                    end else if (idx == 4'(ETH_HDR_LEN - 1)) begin
                        wr_state_n = WR_PAYLOAD;
                    end else begin
                        wr_state_n = WR_HDR;
                    end
                end
                WR_PAYLOAD: begin
                    if (full) begin
                        wr_ptr_n = commit_ptr;
                        if (bus.i_rx_last) begin
                            drops      = drops + 2'd1;
                            wr_state_n = WR_WAIT_SOF;
                        end else begin
                            wr_state_n = WR_DROP;
                        end
                    end else begin
                        we       = 1'b1;
                        wr_ptr_n = wr_ptr + 1'b1;
                        if (bus.i_rx_last) begin
                            wr_state_n = WR_WAIT_SOF;
                            if (bus.i_rx_err) begin
                                drops    = drops + 2'd1;
                                wr_ptr_n = commit_ptr;
                            end else begin
                                commit_n   = wr_ptr + 1'b1;
                                commit_evt = 1'b1;
                            end
                        end
                    end
                end
                WR_DROP: begin
                    if (bus.i_rx_last) begin
                        drops      = drops + 2'd1;
                        wr_ptr_n   = commit_ptr;
                        wr_state_n = WR_WAIT_SOF;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_state   <= WR_WAIT_SOF;
            hdr_idx    <= '0;
            uc_ok      <= 1'b0;
            bc_ok      <= 1'b0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            commit_vis <= '0;
            src_mac    <= '0;
            drop_cnt   <= '0;
        end else begin
            wr_state   <= wr_state_n;
            hdr_idx    <= hdr_idx_n;
            uc_ok      <= uc_ok_n;
            bc_ok      <= bc_ok_n;
            wr_ptr     <= wr_ptr_n;
            commit_ptr <= commit_n;
            commit_vis <= commit_ptr;
            drop_cnt   <= sat_add(drop_cnt, drops);
            if (commit_evt) src_mac <= src_shadow;
        end
    end

    always_ff @(posedge i_clk) begin
        if (shift_src) src_shadow <= {src_shadow[39:0], rx_byte};
    end

    // Read side: commit_vis lags one cycle so a freshly written byte is readable before it is exposed.
    assign rready  = (rd_state == RD_RUN) && (rd_ptr != commit_vis);
    assign pop     = bus.i_rreq && rready;
    assign rd_next = rd_ptr + {{(PW-1){1'b0}}, pop};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr   <= '0;
            rd_state <= RD_RUN;
            gap_cnt  <= '0;
        end else begin
            rd_ptr <= rd_next;
            if (rd_state == RD_RUN) begin
                if (pop && rd_word[8]) begin
                    rd_state <= RD_GAP;
                    gap_cnt  <= '0;
                end
            end else if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                rd_state <= RD_RUN;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    ram_sdp #(.AW(DEPTH_LOG2), .DW(9)) u_ram (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .we    (we),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata ({bus.i_rx_last, rx_byte}),
        .raddr (rd_next[DEPTH_LOG2-1:0]),
        .rdata (rd_word)
    );

    assign bus.o_rdata    = rd_word[7:0];
    assign bus.o_rlast    = rd_word[8];
    assign bus.o_rready   = rready;
    assign bus.o_src_mac  = src_mac;
    assign bus.o_drop_cnt = drop_cnt;
endmodule

// File: tb/tb_eth_rx_payload_buf.sv
// Directed bench for eth_rx_payload_buf with a 16-byte store.
module tb_eth_rx_payload_buf;
    import eth_pkg::*;

    localparam int          GAP    = 64;
    localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
    localparam logic [15:0] ET     = 16'h88B5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   gap_len;
    logic [7:0] pl [0:39];

    eth_rx_payload_buf_if bus();

    eth_rx_payload_buf #(
        .DEPTH_LOG2 (4),
        .MAC_ADDR   (MY_MAC),
        .ETHERTYPE  (ET),
        .GAP_CYCLES (GAP)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] d, input logic s, input logic l, input logic e);
        bus.i_rx_data  = d;
        bus.i_rx_valid = 1'b1;
        bus.i_rx_sof   = s;
        bus.i_rx_last  = l;
        bus.i_rx_err   = e;
        step();
        bus.i_rx_valid = 1'b0;
        bus.i_rx_sof   = 1'b0;
        bus.i_rx_last  = 1'b0;
        bus.i_rx_err   = 1'b0;
    endtask

    // Sends header plus payload pl[off .. off+n-1]; stops without i_rx_last after 'cut' payload bytes.
    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                              input int off, input int n, input int cut, input logic err);
        logic [7:0] b;
        for (int i = 0; i < 14; i++) begin
            if (i < 6)       b = dst[47-8*i -: 8];
            else if (i < 12) b = src[47-8*(i-6) -: 8];
            else if (i == 12) b = et[15:8];
            else             b = et[7:0];
            put(b, i == 0, (n == 0) && (i == 13), err && (n == 0) && (i == 13));
        end
        for (int i = 0; i < n && i < cut; i++)
            put(pl[off+i], 1'b0, i == n - 1, err && (i == n - 1));
    endtask

    // Pops n bytes with i_rreq high, checking each against pl[off..]; leaves i_rreq high.
    task automatic pop_n(input string tag, input int off, input int n);
        bus.i_rreq = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_rdy"}, 48'(bus.o_rready), 48'd1);
            chk({tag, "_data"}, 48'(bus.o_rdata), 48'(pl[off+i]));
            chk({tag, "_last"}, 48'(bus.o_rlast), 48'(i == n - 1));
            step();
        end
    endtask

    initial begin
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_sof   = 1'b0;
        bus.i_rx_last  = 1'b0;
        bus.i_rx_err   = 1'b0;
        bus.i_rreq     = 1'b0;
        repeat (3) step();
        chk("rst_rready", 48'(bus.o_rready), 48'd0);
        chk("rst_rlast", 48'(bus.o_rlast), 48'd0);
        chk("rst_rdata", 48'(bus.o_rdata), 48'd0);
        chk("rst_src", bus.o_src_mac, 48'd0);
        chk("rst_drop", 48'(bus.o_drop_cnt), 48'd0);
        rst = 1'b0;
        step();

        // Unicast frame 01..05: ready two cycles after the last byte.
        for (int i = 0; i < 5; i++) pl[i] = 8'(i + 1);
        send_frame(MY_MAC, 48'h11_22_33_44_55_66, ET, 0, 5, 99, 1'b0);
        chk("t1_rdy_lat1", 48'(bus.o_rready), 48'd0);
        step();
        chk("t1_rdy_lat2", 48'(bus.o_rready), 48'd1);
        chk("t1_src", bus.o_src_mac, 48'h11_22_33_44_55_66);
        pop_n("t1", 0, 5);
        bus.i_rreq = 1'b0;
        chk("t1_empty", 48'(bus.o_rready), 48'd0);
        repeat (GAP + 4) step();

        // Wrong ethertype is dropped.
        send_frame(MY_MAC, 48'h77_77_77_77_77_77, 16'h0800, 0, 4, 99, 1'b0);
        repeat (3) step();
        chk("t2_rdy", 48'(bus.o_rready), 48'd0);
        chk("t2_drop", 48'(bus.o_drop_cnt), 48'd1);
        chk("t2_src", bus.o_src_mac, 48'h11_22_33_44_55_66);

        // Errored frame dropped, following good frame AA BB delivered.
        send_frame(MY_MAC, 48'hA1_A2_A3_A4_A5_A6, ET, 0, 3, 99, 1'b1);
        repeat (3) step();
        chk("t3_err_rdy", 48'(bus.o_rready), 48'd0);
        chk("t3_drop", 48'(bus.o_drop_cnt), 48'd2);
        pl[0] = 8'hAA;
        pl[1] = 8'hBB;
        send_frame(MY_MAC, 48'h0A_0B_0C_0D_0E_0F, ET, 0, 2, 99, 1'b0);
        step();
        chk("t3_rdy", 48'(bus.o_rready), 48'd1);
        chk("t3_src", bus.o_src_mac, 48'h0A_0B_0C_0D_0E_0F);
        pop_n("t3", 0, 2);
        bus.i_rreq = 1'b0;
        repeat (GAP + 4) step();

        // Store exactly full with 16 bytes; a 20-byte frame overflows and is dropped.
        for (int i = 0; i < 16; i++) pl[i] = 8'(8'h30 + i);
        for (int i = 0; i < 20; i++) pl[16+i] = 8'(8'h50 + i);
        send_frame(MY_MAC, 48'h21_22_23_24_25_26, ET, 0, 16, 99, 1'b0);
        send_frame(MY_MAC, 48'h31_32_33_34_35_36, ET, 16, 20, 99, 1'b0);
        step();
        chk("t4_drop", 48'(bus.o_drop_cnt), 48'd3);
        chk("t4_src", bus.o_src_mac, 48'h21_22_23_24_25_26);
        pop_n("t4", 0, 16);
        bus.i_rreq = 1'b0;
        chk("t4_empty", 48'(bus.o_rready), 48'd0);
        repeat (GAP + 4) step();

        // Two committed frames drained with i_rreq held high across the gap.
        pl[0] = 8'h10; pl[1] = 8'h11; pl[2] = 8'h12;
        pl[3] = 8'h20; pl[4] = 8'h21;
        send_frame(MY_MAC, 48'h41_42_43_44_45_46, ET, 0, 3, 99, 1'b0);
        send_frame(MY_MAC, 48'h51_52_53_54_55_56, ET, 3, 2, 99, 1'b0);
        step();
        pop_n("t5a", 0, 3);
        gap_len = 0;
        while (!bus.o_rready && gap_len < 200) begin
            gap_len++;
            step();
        end
        chk("t5_gap", 48'(gap_len), 48'(GAP));
        pop_n("t5b", 3, 2);
        bus.i_rreq = 1'b0;
        repeat (GAP + 4) step();

        // SOF mid-payload drops the partial frame; broadcast frame then delivered.
        pl[0] = 8'hE0; pl[1] = 8'hE1; pl[2] = 8'hE2; pl[3] = 8'hE3;
        pl[4] = 8'hC1; pl[5] = 8'hC2;
        send_frame(MY_MAC, 48'h61_62_63_64_65_66, ET, 0, 4, 2, 1'b0);
        send_frame(ETH_BCAST, 48'hB1_B2_B3_B4_B5_B6, ET, 4, 2, 99, 1'b0);
        step();
        chk("t6_rdy", 48'(bus.o_rready), 48'd1);
        chk("t6_drop", 48'(bus.o_drop_cnt), 48'd4);
        chk("t6_src", bus.o_src_mac, 48'hB1_B2_B3_B4_B5_B6);
        pop_n("t6", 4, 2);
        bus.i_rreq = 1'b0;
        repeat (GAP + 4) step();

        // Reset mid-frame; the tail of that frame is ignored, the next frame is delivered.
        pl[6] = 8'hD0; pl[7] = 8'hD1; pl[8] = 8'hD2; pl[9] = 8'hD3;
        send_frame(MY_MAC, 48'h71_72_73_74_75_76, ET, 6, 4, 2, 1'b0);
        rst = 1'b1;
        step();
        chk("t7_rready", 48'(bus.o_rready), 48'd0);
        chk("t7_rlast", 48'(bus.o_rlast), 48'd0);
        chk("t7_rdata", 48'(bus.o_rdata), 48'd0);
        chk("t7_src", bus.o_src_mac, 48'd0);
        chk("t7_drop", 48'(bus.o_drop_cnt), 48'd0);
        rst = 1'b0;
        put(pl[8], 1'b0, 1'b0, 1'b0);
        put(pl[9], 1'b0, 1'b1, 1'b0);
        repeat (3) step();
        chk("t7_tail_rdy", 48'(bus.o_rready), 48'd0);
        chk("t7_tail_drop", 48'(bus.o_drop_cnt), 48'd0);
        pl[10] = 8'hF1; pl[11] = 8'hF2; pl[12] = 8'hF3;
        send_frame(MY_MAC, 48'h66_55_44_33_22_11, ET, 10, 3, 99, 1'b0);
        step();
        chk("t7_rdy", 48'(bus.o_rready), 48'd1);
        chk("t7_src2", bus.o_src_mac, 48'h66_55_44_33_22_11);
        pop_n("t7", 10, 3);
        bus.i_rreq = 1'b0;
        chk("t7_empty", 48'(bus.o_rready), 48'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
